// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with NZCV flag register, stall counter and an optional
// forwarding tap (enabled by defining EXMEM_FWD_EN; tied to zero otherwise).
module ex_mem_stage #(
  parameter int WIDTH   = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_result,
  input  logic [WIDTH-1:0]   in_store_data,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic               in_set_flags,
  input  logic [1:0]         in_cv,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_result,
  output logic [WIDTH-1:0]   out_store_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic [3:0]         flags,
  output logic [15:0]        stall_cnt,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [WIDTH-1:0]   fwd_data
);

  localparam logic [RADDR_W-1:0] XZR = '1;

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      flags          <= 4'b0000;
      stall_cnt      <= 16'd0;
    end else if (flush) begin
      // Bubble: kill the controls, leave data and rd where they were.
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
    end else if (stall) begin
      if (stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end else begin
      out_valid      <= in_valid;
      out_result     <= in_result;
      out_store_data <= in_store_data;
      out_rd         <= in_rd;
      out_reg_write  <= in_valid & in_reg_write & (in_rd != XZR);
      out_mem_read   <= in_valid & in_mem_read;
      out_mem_write  <= in_valid & in_mem_write;
      if (in_valid && in_set_flags) begin
        flags <= {in_result[WIDTH-1], (in_result == '0), in_cv};
      end
    end
  end

`ifdef EXMEM_FWD_EN
  assign fwd_valid = out_valid & out_reg_write;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vectors plus randomized traffic
// compared every cycle against a transaction-level model of the stage.
module tb_ex_mem_stage;

  localparam int WIDTH   = 64;
  localparam int RADDR_W = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [WIDTH-1:0]   in_result;
  logic [WIDTH-1:0]   in_store_data;
  logic [RADDR_W-1:0] in_rd;
  logic               in_reg_write, in_mem_read, in_mem_write, in_set_flags;
  logic [1:0]         in_cv;
  logic               stall, flush;
  logic               out_valid;
  logic [WIDTH-1:0]   out_result, out_store_data;
  logic [RADDR_W-1:0] out_rd;
  logic               out_reg_write, out_mem_read, out_mem_write;
  logic [3:0]         flags;
  logic [15:0]        stall_cnt;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [WIDTH-1:0]   fwd_data;

  ex_mem_stage #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_result(in_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_set_flags(in_set_flags), .in_cv(in_cv),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .flags(flags), .stall_cnt(stall_cnt),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the architectural view of what the MEM stage holds.
  typedef struct {
    bit         valid;
    bit [63:0]  result;
    bit [63:0]  store;
    int         rd;
    bit         rw, mr, mw;
    bit [3:0]   nzcv;
    int         scnt;
  } mem_view_t;

  mem_view_t m;

  function automatic void model_step();
    if (reset) begin
      m = '{default: 0};
      return;
    end
    if (flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      return;
    end
    if (stall) begin
      m.scnt = (m.scnt + 1 > 65535) ? 65535 : m.scnt + 1;
      return;
    end
    m.valid  = in_valid;
    m.result = in_result;
    m.store  = in_store_data;
    m.rd     = int'(in_rd);
    m.rw     = in_valid && in_reg_write && (int'(in_rd) != 31);
    m.mr     = in_valid && in_mem_read;
    m.mw     = in_valid && in_mem_write;
    if (in_valid && in_set_flags)
      m.nzcv = {in_result[63], in_result == 64'd0, in_cv[1], in_cv[0]};
  endfunction

  task automatic compare_model();
    bit fv;
    fv = m.valid && m.rw;
    check("m_valid",  64'(out_valid),      64'(m.valid));
    check("m_result", out_result,          m.result);
    check("m_store",  out_store_data,      m.store);
    check("m_rd",     64'(out_rd),         64'(m.rd));
    check("m_rw",     64'(out_reg_write),  64'(m.rw));
    check("m_mr",     64'(out_mem_read),   64'(m.mr));
    check("m_mw",     64'(out_mem_write),  64'(m.mw));
    check("m_flags",  64'(flags),          64'(m.nzcv));
    check("m_scnt",   64'(stall_cnt),      64'(m.scnt));
`ifdef EXMEM_FWD_EN
    check("m_fwd_v",  64'(fwd_valid),      64'(fv));
    check("m_fwd_rd", 64'(fwd_rd),         fv || m.valid ? 64'(m.rd) : 64'(m.rd));
    check("m_fwd_d",  fwd_data,            m.result);
`else
    check("m_fwd_v",  64'(fwd_valid),      64'(fv && 1'b0));
    check("m_fwd_rd", 64'(fwd_rd),         64'd0);
    check("m_fwd_d",  fwd_data,            64'd0);
`endif
  endtask

  // Inputs are stable before the edge; the model advances on the same edge
  // and outputs are sampled 1 time unit later.
  task automatic tick(input bit do_cmp);
    @(posedge clk);
    model_step();
    #1;
    if (do_cmp) compare_model();
  endtask

  task automatic idle_in();
    reset = 0; stall = 0; flush = 0;
    in_valid = 0; in_result = '0; in_store_data = '0; in_rd = '0;
    in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; in_set_flags = 0; in_cv = 2'b00;
  endtask

  task automatic load(input logic [63:0] res, input int rd, input bit rw, input bit mw,
                      input bit sf, input logic [1:0] cv);
    idle_in();
    in_valid = 1; in_result = res; in_store_data = ~res; in_rd = RADDR_W'(rd);
    in_reg_write = rw; in_mem_write = mw; in_set_flags = sf; in_cv = cv;
    tick(1);
  endtask

  initial begin
    m = '{default: 0};
    idle_in();

    // Reset with a garbage instruction and hazards asserted.
    reset = 1; stall = 1; flush = 1; in_valid = 1; in_result = 64'hDEAD; in_reg_write = 1;
    in_set_flags = 1;
    tick(1); tick(1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'(flags),     64'd0);
    check("rst_scnt",  64'(stall_cnt), 64'd0);

    // Basic load.
    load(64'h45, 3, 1, 0, 0, 2'b00);
    check("ld_valid",  64'(out_valid),     64'd1);
    check("ld_result", out_result,         64'h45);
    check("ld_rd",     64'(out_rd),        64'd3);
    check("ld_rw",     64'(out_reg_write), 64'd1);

    // Write to XZR is suppressed; the store still goes out.
    load(64'h10, 31, 1, 1, 0, 2'b00);
    check("xzr_rw", 64'(out_reg_write), 64'd0);
    check("xzr_mw", 64'(out_mem_write), 64'd1);

    // Flag updates and hold.
    load(64'h0, 1, 0, 0, 1, 2'b10);
    check("flags_zc", 64'(flags), 64'h6);
    load(64'h8000_0000_0000_0000, 1, 0, 0, 1, 2'b01);
    check("flags_nv", 64'(flags), 64'h9);
    load(64'h1234, 5, 1, 0, 0, 2'b11);
    check("flags_hold", 64'(flags), 64'h9);

    // Three stalled cycles with new inputs offered: everything holds.
    for (int i = 0; i < 3; i++) begin
      idle_in(); stall = 1; in_valid = 1; in_result = 64'hBAD0 + 64'(i); in_rd = 9;
      in_set_flags = 1; in_cv = 2'b11;
      tick(1);
    end
    check("stall_result", out_result,     64'h1234);
    check("stall_rd",     64'(out_rd),    64'd5);
    check("stall_valid",  64'(out_valid), 64'd1);
    check("stall_cnt3",   64'(stall_cnt), 64'd3);

    // Flush wins over stall; flags and counter untouched.
    idle_in(); stall = 1; flush = 1; in_valid = 1; in_set_flags = 1; in_result = 64'h0;
    in_cv = 2'b10;
    tick(1);
    check("flush_valid",  64'(out_valid),  64'd0);
    check("flush_flags",  64'(flags),      64'h9);
    check("flush_scnt",   64'(stall_cnt),  64'd3);
    check("flush_result", out_result,      64'h1234);

    // Forwarding tap.
    load(64'h90, 7, 1, 0, 0, 2'b00);
`ifdef EXMEM_FWD_EN
    check("fwd_valid", 64'(fwd_valid), 64'd1);
    check("fwd_rd",    64'(fwd_rd),    64'd7);
    check("fwd_data",  fwd_data,       64'h90);
`else
    check("fwd_valid", 64'(fwd_valid), 64'd0);
    check("fwd_rd",    64'(fwd_rd),    64'd0);
    check("fwd_data",  fwd_data,       64'd0);
`endif

    // Reset mid-stream overrides stall and discards the instruction.
    load(64'h77, 4, 1, 1, 1, 2'b11);
    idle_in(); reset = 1; stall = 1; in_valid = 1; in_result = 64'h55;
    tick(1);
    check("mrst_valid",  64'(out_valid),     64'd0);
    check("mrst_result", out_result,         64'd0);
    check("mrst_mw",     64'(out_mem_write), 64'd0);
    check("mrst_flags",  64'(flags),         64'd0);
    check("mrst_scnt",   64'(stall_cnt),     64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 99) < 3);
      flush         = ($urandom_range(0, 99) < 12);
      stall         = ($urandom_range(0, 99) < 25);
      in_valid      = ($urandom_range(0, 99) < 75);
      in_result     = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      in_store_data = {$urandom, $urandom};
      in_rd         = ($urandom_range(0, 5) == 0) ? 5'd31 : RADDR_W'($urandom);
      in_reg_write  = 1'($urandom);
      in_mem_read   = 1'($urandom);
      in_mem_write  = 1'($urandom);
      in_set_flags  = 1'($urandom);
      in_cv         = 2'($urandom);
      tick(1);
    end

    // Counter saturation: reach 16'hFFFE, then three more stalls.
    idle_in(); reset = 1;
    tick(1);
    idle_in(); stall = 1; in_valid = 1; in_result = 64'h3;
    for (int i = 0; i < 65534; i++) tick(0);
    check("sat_fffe", 64'(stall_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) tick(1);
    check("sat_ffff", 64'(stall_cnt), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, datapath width.
REQ-002 The block SHALL have parameter RADDR_W, default 5, register-address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an EX instruction is present.
REQ-006 The block SHALL have port in_result, input, WIDTH, the ALU result (AND/OR/XOR/ADD/SUB output).
REQ-007 The block SHALL have port in_store_data, input, WIDTH, the STUR data operand.
REQ-008 The block SHALL have port in_rd, input, RADDR_W, the destination register.
REQ-009 The block SHALL have ports in_reg_write, in_mem_read, in_mem_write and in_set_flags, each input, 1, the control bits.
REQ-010 The block SHALL have port in_cv, input, 2, the ALU carry [1] and overflow [0].
REQ-011 The block SHALL have ports stall and flush, each input, 1, the hazard-unit controls.
REQ-012 The block SHALL have port out_valid, output, 1, meaning the MEM-stage instruction is present.
REQ-013 The block SHALL have ports out_result and out_store_data, each output, WIDTH, the registered data.
REQ-014 The block SHALL have port out_rd, output, RADDR_W, the registered destination.
REQ-015 The block SHALL have ports out_reg_write, out_mem_read and out_mem_write, each output, 1, the registered controls.
REQ-016 The block SHALL have port flags, output, 4, the architectural NZCV register {N,Z,C,V}.
REQ-017 The block SHALL have port stall_cnt, output, 16, a saturating count of stalled cycles.
REQ-018 The block SHALL have ports fwd_valid (output, 1), fwd_rd (output, RADDR_W) and fwd_data (output, WIDTH), the forwarding source.

Function
REQ-019 Per-cycle priority SHALL be reset > flush > stall > load.
REQ-020 On load (no reset, flush or stall), all out_* SHALL take the in_* values one cycle later; latency is exactly 1 cycle.
REQ-021 On load, out_reg_write SHALL be in_reg_write AND (in_rd != all-ones), so writes to XZR (register 31) are suppressed.
REQ-022 When stall=1 and flush=0, all out_* and flags SHALL hold their values.
REQ-023 When flush=1, the block SHALL insert a bubble: out_valid, out_reg_write, out_mem_read and out_mem_write go to 0, and the data/rd outputs hold.
REQ-024 Flush SHALL take precedence over a simultaneous stall.
REQ-025 flags SHALL update only when the cycle is a load with in_valid=1 and in_set_flags=1.
REQ-026 On a flag update: N=in_result[WIDTH-1], Z=(in_result==0), C=in_cv[1], V=in_cv[0].
REQ-027 On a flag update, flags SHALL be visible the cycle after the update.
REQ-028 An instruction that is flushed or invalid SHALL never modify flags.
REQ-029 When in_valid=0 on a load, out_valid=0 and all out_* write/mem controls SHALL be 0.
REQ-030 stall_cnt SHALL increment by 1 in each cycle with stall=1 and flush=0.
REQ-031 stall_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.

Reset
REQ-032 While reset=1 at a clk edge, out_valid, all control outputs, out_result, out_store_data, out_rd, flags and stall_cnt SHALL all go to 0.
REQ-033 Reset SHALL override stall and flush in the same cycle.
REQ-034 An instruction in flight at reset SHALL be discarded.
REQ-035 After reset, the first load SHALL behave per REQ-020.

Configuration
REQ-036 With macro EXMEM_FWD_EN defined: fwd_valid=out_valid AND out_reg_write, fwd_rd=out_rd, fwd_data=out_result, all combinational from the registers.
REQ-037 With EXMEM_FWD_EN undefined: fwd_valid, fwd_rd and fwd_data SHALL be tied to 0, and no other behaviour changes.

Verification
REQ-038 Load: in_valid=1, in_result=64'h45, in_rd=3, in_reg_write=1 -> next cycle out_valid=1, out_result=64'h45, out_rd=3, out_reg_write=1.
REQ-039 XZR: in_rd=31, in_reg_write=1, in_mem_write=1 -> out_reg_write=0, out_mem_write=1.
REQ-040 Flags: in_set_flags=1, in_result=0, in_cv=2'b10 -> flags=4'b0110; then in_result=64'h8000_0000_0000_0000, in_cv=2'b01 -> flags=4'b1001; then in_set_flags=0 -> flags hold 4'b1001.
REQ-041 Stall/flush: stall=1 for 3 cycles -> outputs hold and stall_cnt=3; then stall=1 with flush=1 and in_set_flags=1 -> out_valid=0, flags unchanged, stall_cnt stays 3.
REQ-042 Reset mid-stream: after a valid load, reset=1 with stall=1 -> all outputs and flags 0 next cycle; stall_cnt preset to 16'hFFFE with stall held 3 cycles -> stall_cnt ends at 16'hFFFF.
REQ-043 Forwarding: with EXMEM_FWD_EN defined, a load of in_rd=7, in_result=64'h90 -> fwd_valid=1, fwd_rd=7, fwd_data=64'h90; with the macro undefined -> all fwd_* are 0.
